// File: rtl/lab4_net_terminal_adapter.sv
// Two-entry registered FIFO: 1-cycle enqueue-to-head latency, no full-cycle bypass.
// Backpressure: enq_rdy is low whenever both entries are occupied.
module lab4_net_terminal_fifo #(
  parameter int p_width = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_vld,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_dat,
  output logic               deq_vld,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_dat
);
  logic [p_width-1:0] mem [2];
  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic               enq_fire;
  logic               deq_fire;

  assign enq_rdy  = (count < 2'd2);
  assign deq_vld  = (count != 2'd0);
  assign deq_dat  = mem[rd_ptr];
  assign enq_fire = enq_vld && enq_rdy;
  assign deq_fire = deq_vld && deq_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= ~wr_ptr;
      if (deq_fire) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, enq_fire} - {1'b0, deq_fire};
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr] <= enq_dat;
  end
endmodule

// Ring terminal adapter: stamps injections with src/per-dest sequence, checks ejections for dest and order.
// Both paths are independent 2-entry FIFOs (1-cycle latency); each rdy drops only when its FIFO is full.
module lab4_net_terminal_adapter #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 8,
  parameter int p_num_ports     = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [1:0]                                router_id,
  input  logic                                      term_req_val,
  output logic                                      term_req_rdy,
  input  logic [1:0]                                term_req_dest,
  input  logic [p_payload_nbits-1:0]                term_req_payload,
  output logic                                      net_out_val,
  input  logic                                      net_out_rdy,
  output logic [4+p_opaque_nbits+p_payload_nbits-1:0] net_out_msg,
  input  logic                                      net_in_val,
  output logic                                      net_in_rdy,
  input  logic [4+p_opaque_nbits+p_payload_nbits-1:0] net_in_msg,
  output logic                                      term_resp_val,
  input  logic                                      term_resp_rdy,
  output logic [1:0]                                term_resp_src,
  output logic [p_payload_nbits-1:0]                term_resp_payload,
  output logic                                      err_dest,
  output logic                                      err_seq
);
  typedef struct packed {
    logic [1:0]                 dest;
    logic [1:0]                 src;
    logic [p_opaque_nbits-1:0]  opaque;
    logic [p_payload_nbits-1:0] payload;
  } msg_t;

  typedef struct packed {
    logic [1:0]                 src;
    logic [p_payload_nbits-1:0] payload;
  } resp_t;

  logic [p_opaque_nbits-1:0] inj_seq [p_num_ports];
  logic [p_opaque_nbits-1:0] exp_seq [p_num_ports];
  msg_t  inj_msg;
  msg_t  in_msg;
  resp_t ej_in;
  resp_t ej_out;
  logic  inj_fire;
  logic  ej_fire;

  assign inj_msg  = '{dest: term_req_dest, src: router_id,
                      opaque: inj_seq[term_req_dest], payload: term_req_payload};
  assign in_msg   = msg_t'(net_in_msg);
  assign ej_in    = '{src: in_msg.src, payload: in_msg.payload};
  assign inj_fire = term_req_val && term_req_rdy;
  assign ej_fire  = net_in_val && net_in_rdy;

  assign term_resp_src     = ej_out.src;
  assign term_resp_payload = ej_out.payload;

  lab4_net_terminal_fifo #(.p_width($bits(msg_t))) u_inj_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_vld (term_req_val),
    .enq_rdy (term_req_rdy),
    .enq_dat (inj_msg),
    .deq_vld (net_out_val),
    .deq_rdy (net_out_rdy),
    .deq_dat (net_out_msg)
  );

  lab4_net_terminal_fifo #(.p_width($bits(resp_t))) u_ej_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_vld (net_in_val),
    .enq_rdy (net_in_rdy),
    .enq_dat (ej_in),
    .deq_vld (term_resp_val),
    .deq_rdy (term_resp_rdy),
    .deq_dat (ej_out)
  );

  // Expected sequence always resyncs to the received value, so one gap flags once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_num_ports; i++) begin
        inj_seq[i] <= '0;
        exp_seq[i] <= '0;
      end
      err_dest <= 1'b0;
      err_seq  <= 1'b0;
    end else begin
      if (inj_fire) inj_seq[term_req_dest] <= inj_seq[term_req_dest] + 1'b1;
      if (ej_fire) begin
        exp_seq[in_msg.src] <= in_msg.opaque + 1'b1;
        if (in_msg.dest != router_id)           err_dest <= 1'b1;
        if (in_msg.opaque != exp_seq[in_msg.src]) err_seq <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lab4_net_terminal_adapter.sv
// Scoreboard bench for lab4_net_terminal_adapter: inject/eject drivers push expectations, negedge monitors pop them.
module tb_lab4_net_terminal_adapter;
  localparam int PW = 32;
  localparam int OW = 8;
  localparam int W  = 4 + OW + PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    router_id = 2'd0;
  logic          term_req_val = 1'b0;
  logic          term_req_rdy;
  logic [1:0]    term_req_dest = 2'd0;
  logic [PW-1:0] term_req_payload = '0;
  logic          net_out_val;
  logic          net_out_rdy = 1'b0;
  logic [W-1:0]  net_out_msg;
  logic          net_in_val = 1'b0;
  logic          net_in_rdy;
  logic [W-1:0]  net_in_msg = '0;
  logic          term_resp_val;
  logic          term_resp_rdy = 1'b0;
  logic [1:0]    term_resp_src;
  logic [PW-1:0] term_resp_payload;
  logic          err_dest;
  logic          err_seq;

  int tests_run = 0;
  int fails = 0;

  logic [W-1:0]    out_q[$];
  logic [2+PW-1:0] resp_q[$];
  logic [OW-1:0]   inj_seq_m [4];
  logic [OW-1:0]   exp_seq_m [4];
  logic            err_dest_m;
  logic            err_seq_m;

  lab4_net_terminal_adapter dut (
    .clk               (clk),
    .reset             (reset),
    .router_id         (router_id),
    .term_req_val      (term_req_val),
    .term_req_rdy      (term_req_rdy),
    .term_req_dest     (term_req_dest),
    .term_req_payload  (term_req_payload),
    .net_out_val       (net_out_val),
    .net_out_rdy       (net_out_rdy),
    .net_out_msg       (net_out_msg),
    .net_in_val        (net_in_val),
    .net_in_rdy        (net_in_rdy),
    .net_in_msg        (net_in_msg),
    .term_resp_val     (term_resp_val),
    .term_resp_rdy     (term_resp_rdy),
    .term_resp_src     (term_resp_src),
    .term_resp_payload (term_resp_payload),
    .err_dest          (err_dest),
    .err_seq           (err_seq)
  );

  always #5 clk = ~clk;

  // Output monitors: a transfer seen valid&&ready at negedge fires on the next posedge.
  always @(negedge clk) begin
    if (!reset && net_out_val && net_out_rdy) begin
      tests_run++;
      if (out_q.size() == 0) begin
        fails++;
        $display("FAIL net_out_unexpected: got %h, none expected", net_out_msg);
      end else begin
        logic [W-1:0] exp_msg;
        exp_msg = out_q.pop_front();
        if (net_out_msg !== exp_msg) begin
          fails++;
          $display("FAIL net_out_msg: got %h, expected %h", net_out_msg, exp_msg);
        end
      end
    end
    if (!reset && term_resp_val && term_resp_rdy) begin
      tests_run++;
      if (resp_q.size() == 0) begin
        fails++;
        $display("FAIL term_resp_unexpected: got src %0d payload %h, none expected",
                 term_resp_src, term_resp_payload);
      end else begin
        logic [2+PW-1:0] exp_resp;
        exp_resp = resp_q.pop_front();
        if ({term_resp_src, term_resp_payload} !== exp_resp) begin
          fails++;
          $display("FAIL term_resp: got %h, expected %h", {term_resp_src, term_resp_payload}, exp_resp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      inj_seq_m[i] = '0;
      exp_seq_m[i] = '0;
    end
    err_dest_m = 1'b0;
    err_seq_m  = 1'b0;
    out_q.delete();
    resp_q.delete();
  endtask

  task automatic do_reset(input logic [1:0] id);
    reset        = 1'b1;
    term_req_val = 1'b0;
    net_in_val   = 1'b0;
    router_id    = id;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Returns at #1 after the edge where the request fired.
  task automatic inject(input logic [1:0] dest, input logic [PW-1:0] payload);
    bit ok = 0;
    term_req_val     = 1'b1;
    term_req_dest    = dest;
    term_req_payload = payload;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (term_req_rdy) begin
        out_q.push_back({dest, router_id, inj_seq_m[dest], payload});
        inj_seq_m[dest] = inj_seq_m[dest] + 1'b1;
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    term_req_val = 1'b0;
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL inject_timeout: accepted %0d, expected 1", ok);
    end
  endtask

  task automatic eject(input logic [1:0] dest, input logic [1:0] src,
                       input logic [OW-1:0] opq, input logic [PW-1:0] payload);
    bit ok = 0;
    net_in_val = 1'b1;
    net_in_msg = {dest, src, opq, payload};
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (net_in_rdy) begin
        if (dest != router_id)     err_dest_m = 1'b1;
        if (opq != exp_seq_m[src]) err_seq_m  = 1'b1;
        exp_seq_m[src] = opq + 1'b1;
        resp_q.push_back({src, payload});
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    net_in_val = 1'b0;
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL eject_timeout: accepted %0d, expected 1", ok);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({term_req_rdy, net_in_rdy, net_out_val, term_resp_val, err_dest, err_seq} !== 6'b110000) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected 110000",
               {term_req_rdy, net_in_rdy, net_out_val, term_resp_val, err_dest, err_seq});
    end
    do_reset(2'd2);
    net_out_rdy   = 1'b0;
    term_resp_rdy = 1'b0;
    inject(2'd1, 32'h11);
    inject(2'd1, 32'h22);
    tests_run++;
    if (term_req_rdy !== 1'b0) begin
      fails++;
      $display("FAIL full_inj_rdy: got %b, expected 0", term_req_rdy);
    end
    eject(2'd3, 2'd0, 8'd0, 32'h33);
    eject(2'd2, 2'd1, 8'd5, 32'h44);
    tests_run++;
    if ({net_in_rdy, err_dest, err_seq} !== 3'b011) begin
      fails++;
      $display("FAIL full_ej_rdy_errs: got %b, expected 011", {net_in_rdy, err_dest, err_seq});
    end
    @(posedge clk);
    #3 reset = 1'b1;
    clear_model();
    #1;
    tests_run++;
    if ({term_req_rdy, net_in_rdy, net_out_val, term_resp_val, err_dest, err_seq} !== 6'b110000) begin
      fails++;
      $display("FAIL midcycle_reset: got %b, expected 110000",
               {term_req_rdy, net_in_rdy, net_out_val, term_resp_val, err_dest, err_seq});
    end
    net_out_rdy   = 1'b1;
    term_resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if ({net_out_val, term_resp_val} !== 2'b00) begin
      fails++;
      $display("FAIL post_reset_idle: got %b, expected 00", {net_out_val, term_resp_val});
    end
  endtask

  task automatic test_inject();
    logic [PW-1:0] pl [3];
    pl[0] = 32'hA;
    pl[1] = 32'hB;
    pl[2] = 32'hC;
    net_out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inject(2'd0, pl[i]);
      tests_run++;
      if (net_out_val !== 1'b1 || net_out_msg !== {2'd0, 2'd2, i[7:0], pl[i]}) begin
        fails++;
        $display("FAIL inject_%0d: got val %b msg %h, expected val 1 msg %h",
                 i, net_out_val, net_out_msg, {2'd0, 2'd2, i[7:0], pl[i]});
      end
    end
    inject(2'd3, 32'hD);
    tests_run++;
    if (net_out_msg[39:32] !== 8'd0) begin
      fails++;
      $display("FAIL inject_dest3_opaque: got %0d, expected 0", net_out_msg[39:32]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    logic [W-1:0] first_msg;
    first_msg     = {2'd2, 2'd2, 8'd0, 32'h100};
    net_out_rdy   = 1'b0;
    term_req_val  = 1'b1;
    term_req_dest = 2'd2;
    for (int c = 0; c < 6; c++) begin
      term_req_payload = 32'h100 + accepted;
      @(negedge clk);
      if (c >= 1) begin
        tests_run++;
        if (net_out_val !== 1'b1 || net_out_msg !== first_msg) begin
          fails++;
          $display("FAIL bp_hold_%0d: got val %b msg %h, expected val 1 msg %h",
                   c, net_out_val, net_out_msg, first_msg);
        end
      end
      if (term_req_rdy) begin
        out_q.push_back({2'd2, router_id, inj_seq_m[2], term_req_payload});
        inj_seq_m[2] = inj_seq_m[2] + 1'b1;
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    term_req_val = 1'b0;
    tests_run++;
    if (accepted != 2 || term_req_rdy !== 1'b0) begin
      fails++;
      $display("FAIL bp_accepts: got %0d accepts rdy %b, expected 2 accepts rdy 0", accepted, term_req_rdy);
    end
    net_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (term_req_rdy !== 1'b1 || net_out_val !== 1'b0 || out_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got rdy %b val %b pending %0d, expected rdy 1 val 0 pending 0",
               term_req_rdy, net_out_val, out_q.size());
    end
  endtask

  task automatic test_wrap();
    net_out_rdy = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      inject(2'd1, 32'h2000 + i);
      tests_run++;
      if (net_out_msg[39:32] !== i[7:0]) begin
        fails++;
        $display("FAIL wrap_opaque_%0d: got %0d, expected %0d", i, net_out_msg[39:32], i[7:0]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_eject_order();
    do_reset(2'd1);
    net_out_rdy   = 1'b1;
    term_resp_rdy = 1'b1;
    eject(2'd1, 2'd3, 8'd0, 32'hE0);
    eject(2'd1, 2'd3, 8'd1, 32'hE1);
    tests_run++;
    if (err_seq !== 1'b0) begin
      fails++;
      $display("FAIL eject_in_order_err: got %b, expected 0", err_seq);
    end
    eject(2'd1, 2'd3, 8'd3, 32'hE3);
    tests_run++;
    if (err_seq !== 1'b1) begin
      fails++;
      $display("FAIL eject_gap_err: got %b, expected 1", err_seq);
    end
    eject(2'd1, 2'd3, 8'd4, 32'hE4);
    tests_run++;
    if ({err_dest, err_seq} !== {err_dest_m, err_seq_m} || err_dest !== 1'b0) begin
      fails++;
      $display("FAIL eject_resync_flags: got %b, expected %b", {err_dest, err_seq}, {err_dest_m, err_seq_m});
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_misroute_simul();
    fork
      inject(2'd0, 32'h55);
      eject(2'd2, 2'd0, 8'd0, 32'h66);
    join
    tests_run++;
    if (err_dest !== 1'b1 || net_out_val !== 1'b1 || term_resp_val !== 1'b1) begin
      fails++;
      $display("FAIL misroute_simul: got err_dest %b out_val %b resp_val %b, expected 1 1 1",
               err_dest, net_out_val, term_resp_val);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out_q.size() != 0 || resp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", out_q.size(), resp_q.size());
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_inject();
    test_backpressure();
    test_wrap();
    test_eject_order();
    test_misroute_simul();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/lab4_net_terminal_adapter.md
Name: lab4_net_terminal_adapter

Overview:
Terminal-side network interface for the 4-node ring. It sits between a terminal and the router's terminal port (router port 1).
- Injection path: accepts (dest, payload) requests from the terminal, builds a net message stamped with src = router_id and a per-destination sequence number in the opaque field, and buffers it toward the router.
- Ejection path: accepts messages the router delivers on port 1, checks destination and per-source ordering, and presents (src, payload) to the terminal.

Parameters:
p_payload_nbits, 32, payload field width
p_opaque_nbits, 8, opaque/sequence field width
p_num_ports, 4, ring size; src/dest fields are 2 bits, fixed for 4 nodes

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
router_id  input  2  this node's id, static after reset
term_req_val  input  1  terminal injection request valid
term_req_rdy  output  1  adapter can accept injection
term_req_dest  input  2  destination node
term_req_payload  input  p_payload_nbits  payload
net_out_val  output  1  message to router valid
net_out_rdy  input  1  router accepts message
net_out_msg  output  W  {dest[W-1:W-2], src, opaque, payload}, W = 4+p_opaque_nbits+p_payload_nbits (44 at defaults)
net_in_val  input  1  router ejecting a message
net_in_rdy  output  1  adapter accepts ejected message
net_in_msg  input  W  same layout as net_out_msg
term_resp_val  output  1  delivery to terminal valid
term_resp_rdy  input  1  terminal accepts delivery
term_resp_src  output  2  source node of delivered message
term_resp_payload  output  p_payload_nbits  delivered payload
err_dest  output  1  sticky: a message arrived with dest != router_id
err_seq  output  1  sticky: a per-source sequence gap was detected

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is asynchronous and active-high. It immediately clears both queues (count=0, pointers=0), all sequence counters and both error flags.
  - During and after reset: term_req_rdy=1, net_in_rdy=1, net_out_val=0, term_resp_val=0, err_dest=0, err_seq=0. Data outputs are don't-care while the corresponding val=0.
  - Reset asserted mid-transfer drops all buffered messages. No handshake completes in a cycle where reset is high.
- Handshake: a transfer fires on the rising edge where val && rdy.
  - val never depends combinationally on rdy.
  - rdy is a function of registered state only.
- Injection queue: 2-entry FIFO, registered output.
  - term_req_rdy = (inj_count < 2). Full blocks enqueue even if a dequeue occurs in the same cycle (no bypass).
  - On enqueue, store {term_req_dest, router_id, inj_seq[term_req_dest], term_req_payload}, then increment inj_seq[term_req_dest] modulo 2^p_opaque_nbits (255 -> 0).
  - Minimum latency is 1 cycle: a message accepted into an empty queue appears on net_out_msg with net_out_val=1 the next cycle.
  - Messages leave in FIFO order.
  - Simultaneous enqueue and dequeue at count=1 keeps count=1.
  - net_out_msg holds stable while net_out_val=1 && !net_out_rdy.
- Ejection queue: 2-entry FIFO with identical rules. net_in_rdy = (ej_count < 2). term_resp_src and term_resp_payload are taken from the stored message.
- Ejection checks, evaluated on each net_in fire using the incoming message:
  - If dest != router_id, set err_dest on the next edge. The message is still enqueued and delivered.
  - With s = src and q = opaque: if q != exp_seq[s], set err_seq.
  - In all cases, exp_seq[s] <= q+1 (modulo 2^p_opaque_nbits), so the check resyncs after a gap.
  - Both checks apply to a self-addressed message (src = router_id).
- Error flags are sticky until reset.
- Injection and ejection paths are fully independent; both may fire in the same cycle.
- State: 2 queues × 2 entries; inj_seq[4] and exp_seq[4] of p_opaque_nbits each; 2-bit counts; 1-bit pointers.

Test Plan:
- Reset/idle: assert reset mid-cycle with both queues holding messages -> outputs immediately show val=0, rdy=1, err=0; no message emerges afterward.
- Inject: router_id=2, send dest=0 payloads 0xA, 0xB, 0xC with net_out_rdy=1 -> net_out_msg carries {0,2,opaque 0,0xA}, {0,2,1,0xB}, {0,2,2,0xC}, each 1 cycle after acceptance; a subsequent dest=3 request gets opaque 0.
- Backpressure: hold net_out_rdy=0 -> term_req_rdy drops after 2 accepts; message 1 stays stable on net_out_msg; releasing rdy drains in order and rdy returns.
- Wrap: 256 injections to dest=1 followed by one more -> opaque values 0..255, then 0.
- Eject ordering: router_id=1, net_in messages from src=3 with opaque 0, 1, 3 -> all three delivered as (3, payload); err_seq rises after the third; next opaque 4 raises no further event.
- Misroute and simultaneity: ejected message with dest=2 while an injection fires in the same cycle -> err_dest=1; the message is still delivered; the injection proceeds unaffected.
